// File: rtl/moore_jk_array.sv
// Bank of CH independent two-state JK Moore machines with per-channel lockout and rise/fall pulses.
// Optional per-channel saturating transition counters: define MOORE_JK_ARRAY_EVCNT_EN.
//
// state | meaning
// S0    | channel level low (y[i] = 0)
// S1    | channel level high (y[i] = 1)
module moore_jk_array #(
    parameter int CH      = 4,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MOORE_JK_ARRAY_EVCNT_EN
    input  logic               evcnt_clr,
    output logic [CH*8-1:0]    evcnt,
`endif
    input  logic [CH-1:0]      j,
    input  logic [CH-1:0]      k,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [CH-1:0]      y,
    output logic [CH-1:0]      rise,
    output logic [CH-1:0]      fall,
    output logic [CH-1:0]      busy
);

    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } jk_state_e;

    localparam logic [DWELL_W-1:0] CNT_ONE = 1;

    jk_state_e          st   [CH];
    jk_state_e          nxt  [CH];
    logic [DWELL_W-1:0] cnt  [CH];
    logic [CH-1:0]      fire;

    // fire marks a real level change on an unlocked channel; redundant requests never fire
    always_comb begin
        fire = '0;
        y    = '0;
        busy = '0;
        for (int i = 0; i < CH; i++) begin
            nxt[i] = st[i];
            case ({j[i], k[i]})
                2'b10: nxt[i] = S1;
                2'b01: nxt[i] = S0;
                2'b11: begin
                    case (mode)
                        2'b01:   nxt[i] = jk_state_e'(~st[i]);
                        2'b10:   nxt[i] = S1;
                        2'b11:   nxt[i] = S0;
                        default: nxt[i] = st[i];
                    endcase
                end
                default: nxt[i] = st[i];
            endcase
            fire[i] = (cnt[i] == '0) && (nxt[i] != st[i]);
            y[i]    = st[i];
            busy[i] = (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                st[i]  <= S0;
                cnt[i] <= '0;
            end
            rise <= '0;
            fall <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (fire[i]) begin
                    st[i]   <= nxt[i];
                    cnt[i]  <= dwell;
                    rise[i] <= (nxt[i] == S1);
                    fall[i] <= (nxt[i] == S0);
                end else begin
                    rise[i] <= 1'b0;
                    fall[i] <= 1'b0;
                    if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - CNT_ONE;
                    end
                end
            end
        end
    end

`ifdef MOORE_JK_ARRAY_EVCNT_EN
    logic [7:0] ev [CH];

    // clear wins over a same-cycle increment; counters stick at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                ev[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (evcnt_clr) begin
                    ev[i] <= '0;
                end else if (fire[i] && (ev[i] != 8'hFF)) begin
                    ev[i] <= ev[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        evcnt = '0;
        for (int i = 0; i < CH; i++) begin
            evcnt[8*i +: 8] = ev[i];
        end
    end
`endif

endmodule

// File: tb/tb_moore_jk_array.sv
// Self-checking bench for moore_jk_array: directed vector table, hand-written corner sequences,
// and randomized traffic against an integer reference model of the set/clear/lockout rules.
module tb_moore_jk_array;

    localparam int CH      = 4;
    localparam int DWELL_W = 4;

    logic               clk;
    logic               rst_n;
    logic [CH-1:0]      j_v, k_v;
    logic [1:0]         mode_v;
    logic [DWELL_W-1:0] dwell_v;
    logic [CH-1:0]      y, rise, fall, busy;
`ifdef MOORE_JK_ARRAY_EVCNT_EN
    logic               evcnt_clr;
    logic [CH*8-1:0]    evcnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // reference model state, plain integers per channel
    int m_y    [CH];
    int m_lock [CH];
    int m_rise [CH];
    int m_fall [CH];
    int m_ev   [CH];

    moore_jk_array #(.CH(CH), .DWELL_W(DWELL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef MOORE_JK_ARRAY_EVCNT_EN
        .evcnt_clr(evcnt_clr),
        .evcnt    (evcnt),
`endif
        .j        (j_v),
        .k        (k_v),
        .mode     (mode_v),
        .dwell    (dwell_v),
        .y        (y),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_y[i] = 0; m_lock[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_ev[i] = 0;
        end
    endtask

    task automatic model_step();
        int want;
        bit clr;
        clr = 1'b0;
`ifdef MOORE_JK_ARRAY_EVCNT_EN
        clr = evcnt_clr;
`endif
        for (int i = 0; i < CH; i++) begin
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (m_lock[i] > 0) begin
                m_lock[i] = m_lock[i] - 1;
            end else begin
                want = m_y[i];
                if (j_v[i] && !k_v[i]) want = 1;
                else if (!j_v[i] && k_v[i]) want = 0;
                else if (j_v[i] && k_v[i]) begin
                    if (mode_v == 2'd1) want = 1 - m_y[i];
                    else if (mode_v == 2'd2) want = 1;
                    else if (mode_v == 2'd3) want = 0;
                end
                if (want != m_y[i]) begin
                    m_y[i]    = want;
                    m_lock[i] = int'(dwell_v);
                    m_rise[i] = want;
                    m_fall[i] = 1 - want;
                    if (m_ev[i] < 255) m_ev[i] = m_ev[i] + 1;
                end
            end
            if (clr) m_ev[i] = 0;
        end
    endtask

    task automatic compare_model();
        logic [CH-1:0] ey, er, ef, eb;
        for (int i = 0; i < CH; i++) begin
            ey[i] = (m_y[i] != 0);
            er[i] = (m_rise[i] != 0);
            ef[i] = (m_fall[i] != 0);
            eb[i] = (m_lock[i] != 0);
        end
        check("model_y", 32'(y), 32'(ey));
        check("model_rise", 32'(rise), 32'(er));
        check("model_fall", 32'(fall), 32'(ef));
        check("model_busy", 32'(busy), 32'(eb));
`ifdef MOORE_JK_ARRAY_EVCNT_EN
        for (int i = 0; i < CH; i++) begin
            check("model_evcnt", 32'(evcnt[8*i +: 8]), 32'(m_ev[i]));
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_model();
    endtask

    typedef struct {
        logic       j0, k0;
        logic [1:0] mode;
        logic [3:0] dwell;
        logic       y0, r0, f0, b0;
    } vec_t;

    function automatic vec_t mkv(input logic j0, input logic k0, input logic [1:0] md,
                                 input logic [3:0] dw, input logic y0, input logic r0,
                                 input logic f0, input logic b0);
        vec_t v;
        v.j0 = j0; v.k0 = k0; v.mode = md; v.dwell = dw;
        v.y0 = y0; v.r0 = r0; v.f0 = f0; v.b0 = b0;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // ch0 only; the other channels are expected to stay idle at 0
        //                 j  k  mode  dw  y  r  f  b
        tbl.push_back(mkv(1, 0, 2'd0, 0, 1, 1, 0, 0));   // set
        tbl.push_back(mkv(0, 0, 2'd0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 1, 2'd0, 0, 0, 0, 1, 0));   // clear
        tbl.push_back(mkv(0, 0, 2'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 1, 2'd0, 0, 0, 0, 0, 0));   // J=K hold from S0
        tbl.push_back(mkv(1, 1, 2'd1, 0, 1, 1, 0, 0));   // toggle
        tbl.push_back(mkv(1, 1, 2'd1, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(1, 1, 2'd1, 0, 1, 1, 0, 0));
        tbl.push_back(mkv(1, 1, 2'd0, 0, 1, 0, 0, 0));   // hold from S1
        tbl.push_back(mkv(1, 1, 2'd2, 0, 1, 0, 0, 0));   // set-wins in S1
        tbl.push_back(mkv(1, 1, 2'd3, 0, 0, 0, 1, 0));   // clear-wins
        tbl.push_back(mkv(1, 1, 2'd3, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 1, 2'd2, 0, 1, 1, 0, 0));   // set-wins from S0
        tbl.push_back(mkv(0, 1, 2'd0, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(1, 0, 2'd0, 3, 1, 1, 0, 1));   // lockout D=3, edge t
        tbl.push_back(mkv(0, 1, 2'd0, 3, 1, 0, 0, 1));
        tbl.push_back(mkv(0, 1, 2'd0, 3, 1, 0, 0, 1));
        tbl.push_back(mkv(0, 1, 2'd0, 3, 1, 0, 0, 0));   // edge t+3 still ignored
        tbl.push_back(mkv(0, 1, 2'd0, 3, 0, 0, 1, 1));   // falls at t+4
        tbl.push_back(mkv(0, 0, 2'd0, 3, 0, 0, 0, 1));
        tbl.push_back(mkv(0, 0, 2'd0, 3, 0, 0, 0, 1));
        tbl.push_back(mkv(0, 0, 2'd0, 3, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 2'd0, 5, 1, 1, 0, 1));   // D=5 loaded
        tbl.push_back(mkv(0, 1, 2'd0, 1, 1, 0, 0, 1));   // dwell changed mid-lockout
        tbl.push_back(mkv(0, 1, 2'd0, 1, 1, 0, 0, 1));
        tbl.push_back(mkv(0, 1, 2'd0, 1, 1, 0, 0, 1));
        tbl.push_back(mkv(0, 1, 2'd0, 1, 1, 0, 0, 1));
        tbl.push_back(mkv(0, 1, 2'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 2'd0, 1, 1, 0, 0, 0));   // redundant set
        tbl.push_back(mkv(1, 0, 2'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 1, 2'd0, 0, 0, 0, 1, 0));

        rst_n = 1'b0; j_v = '0; k_v = '0; mode_v = '0; dwell_v = '0;
`ifdef MOORE_JK_ARRAY_EVCNT_EN
        evcnt_clr = 1'b0;
`endif
        model_reset();
        j_v = 4'b1111;
        tick();
        tick();
        check("reset_y", 32'(y), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        j_v = '0;
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            j_v = {3'b000, tbl[n].j0};
            k_v = {3'b000, tbl[n].k0};
            mode_v = tbl[n].mode;
            dwell_v = tbl[n].dwell;
            tick();
            check($sformatf("vec%0d_y", n), 32'(y), {28'h0, 3'b000, tbl[n].y0});
            check($sformatf("vec%0d_rise", n), 32'(rise), {28'h0, 3'b000, tbl[n].r0});
            check($sformatf("vec%0d_fall", n), 32'(fall), {28'h0, 3'b000, tbl[n].f0});
            check($sformatf("vec%0d_busy", n), 32'(busy), {28'h0, 3'b000, tbl[n].b0});
        end

        for (int n = 0; n < 600; n++) begin
            j_v = CH'($urandom);
            k_v = CH'($urandom);
            mode_v = 2'($urandom);
            dwell_v = ($urandom_range(0, 3) == 0) ? DWELL_W'($urandom) : DWELL_W'($urandom_range(0, 2));
            tick();
        end

        // async reset mid-lockout on ch1
        j_v = '0; k_v = '1; dwell_v = '0;
        for (int n = 0; n < 18; n++) tick();
        j_v = 4'b0010; k_v = '0; dwell_v = 4'd7;
        tick();
        check("pre_reset_busy1", 32'(busy[1]), 32'h1);
        j_v = '0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_y", 32'(y), 32'h0);
        check("async_busy", 32'(busy), 32'h0);
        check("async_rise", 32'(rise), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        j_v = 4'b0010; dwell_v = '0;
        tick();
        check("post_reset_y1", 32'(y[1]), 32'h1);
        j_v = '0;
        tick();

`ifdef MOORE_JK_ARRAY_EVCNT_EN
        j_v = 4'b0001; k_v = 4'b0001; mode_v = 2'd1; dwell_v = '0;
        evcnt_clr = 1'b1;
        tick();
        check("evcnt_clr_same_cycle", 32'(evcnt[7:0]), 32'h0);
        evcnt_clr = 1'b0;
        for (int n = 0; n < 260; n++) tick();
        check("evcnt_saturate", 32'(evcnt[7:0]), 32'd255);
        evcnt_clr = 1'b1;
        tick();
        check("evcnt_clr_priority", 32'(evcnt[7:0]), 32'h0);
        evcnt_clr = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/moore_jk_array.md
# moore_jk_array

Parametrised bank of CH independent two-state JK Moore machines. Each channel holds a registered level and has a configurable resolution for simultaneous J/K. A post-transition lockout (minimum dwell) blocks the next transition for a set number of cycles, and each transition produces a one-cycle rise or fall pulse. The block replaces scattered single-channel JK state machines in control/status paths where several flags need identical set/clear semantics with glitch suppression.

## Interface
Parameters:
- CH, 4, number of independent channels (≥1)
- DWELL_W, 4, width of the dwell/lockout counter (≥1)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- j  input  CH  per-channel set request
- k  input  CH  per-channel clear request
- mode  input  2  global J=K=1 resolution: 00 hold, 01 toggle, 10 set wins, 11 clear wins
- dwell  input  DWELL_W  lockout length D loaded on each transition
- y  output  CH  per-channel Moore state (0 = S0, 1 = S1), registered
- rise  output  CH  one-cycle pulse, high in the first cycle y[i] is 1
- fall  output  CH  one-cycle pulse, high in the first cycle y[i] is 0 after being 1
- busy  output  CH  channel in lockout (lockout counter ≠ 0)

## Operation
- Per channel i: state bit s[i] and lockout counter c[i] (DWELL_W bits). Channels never interact. mode and dwell are shared by all channels.
- Request decode at each clock edge, evaluated only when c[i]==0:
  - jk=00: hold.
  - jk=10: go to S1.
  - jk=01: go to S0.
  - jk=11: resolved by mode (hold, toggle, S1, or S0).
- A transition happens only when the decoded next state differs from s[i]. A request for the current state (e.g. j=1 in S1) is not a transition. It causes no pulse and no lockout.
- On a transition: s[i] takes the new value, c[i] loads dwell, and rise[i] or fall[i] is set for one cycle.
- While c[i]≠0: j, k and mode are ignored for channel i, and c[i] decrements by 1 per edge.
- dwell=0 disables lockout: back-to-back transitions are possible every cycle, for example toggle mode with J=K=1 gives a y period of 2 cycles.
- A change on dwell during lockout does not affect a running count. dwell is sampled only at the transition edge.
- Outputs: y=s, busy[i]=(c[i]≠0). rise/fall are registered and never asserted together on one channel.

## Timing
- Reset (rst_n low, asynchronous): y=0, c=0, busy=0, rise=0, fall=0, and event counters (if compiled in) = 0. All are held while rst_n=0.
- The first edge after rst_n rises evaluates inputs normally.
- Latency: j/k sampled at edge t → y, rise/fall and busy update at edge t. This means they are visible in the cycle after the request cycle, a 1-cycle latency.
- Lockout: a transition at edge t with D=dwell:
  - c becomes D at edge t, then 0 after edge t+D.
  - Inputs are ignored at edges t+1 … t+D.
  - The earliest next transition is at edge t+D+1, so y holds for at least D+1 cycles.
- busy is high for exactly D cycles after the transition edge.
- Reset asserted mid-lockout: the counter clears immediately, and the channel accepts requests on the first edge after release.

## Configuration
- Macro MOORE_JK_ARRAY_EVCNT_EN, when defined:
  - Adds input evcnt_clr (1 bit, synchronous clear of all counters).
  - Adds output evcnt (CH×8 bits, channel i at [8i+7:8i]).
  - Each channel counts its transitions (rise or fall), saturating at 255.
  - evcnt_clr has priority over a same-cycle increment; the result is 0.
- Macro undefined: these ports and counters do not exist, and all other behaviour is identical.

## Test plan
- Reset and set/clear:
  - Stimulus: hold rst_n=0, then release; on ch0 pulse j=1 for 1 cycle with dwell=0, later pulse k=1 for 1 cycle.
  - Required: y=0 and busy=0 during reset; after the j pulse, y[0]=1 and rise[0]=1 for exactly 1 cycle, with no other channel changing; after the k pulse, y[0]=0 and fall[0]=1 for 1 cycle.
- J=K=1 mode sweep, from S0 and from S1 on one channel, dwell=0:
  - mode=00 gives no change.
  - mode=01 toggles y every cycle.
  - mode=10 gives y=1.
  - mode=11 gives y=0.
- Lockout:
  - Stimulus: dwell=3; set j=1 then hold k=1 continuously.
  - Required: y rises at edge t; busy is high for 3 cycles; y falls at edge t+4, not before.
- Mid-lockout dwell change and redundant request:
  - Stimulus: dwell=5 at the transition, change dwell to 1 during lockout; separately, hold j=1 while already in S1.
  - Required: lockout still lasts 5 cycles; the redundant j=1 produces no rise and no busy.
- Async reset during lockout:
  - Stimulus: drop rst_n with busy=1.
  - Required: y=0 and busy=0 immediately, before the next edge; j=1 on the first edge after release sets y=1.
- Event counter (macro defined), dwell=0, mode=01, j=k=1:
  - Required: evcnt[7:0] reaches 255 after 255 transitions and stays at 255.
  - evcnt_clr on the same cycle as a transition gives 0.
